counter_gen: RTL

COUNTER_GEN -- requirements
Module: counter_gen

---
 rtl/counter_gen.sv | 85 ++++++++
 1 files changed

// File: rtl/counter_gen.sv
// Prescaled up/down counter with wrap or saturate limit handling.
// Registered tick/wrap/match pulses; combinational sat level.
module counter_gen #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PSC_W-1:0] psc,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             match,
  output logic             sat
);

  logic [PSC_W-1:0] psc_cnt;
  logic             step;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;

  // A lowered psc still steps immediately thanks to the >= compare.
  assign step   = en && (psc_cnt >= psc);
  assign at_max = (count == {WIDTH{1'b1}});
  assign at_min = (count == '0);
  assign sat    = mode && ((dir && at_max) || (!dir && at_min));

  always_comb begin
    step_count = count;
    step_wrap  = 1'b0;
    if (dir) begin
      if (!at_max) begin
        step_count = count + WIDTH'(1);
      end else if (!mode) begin
        step_count = '0;
        step_wrap  = 1'b1;
      end
    end else begin
      if (!at_min) begin
        step_count = count - WIDTH'(1);
      end else if (!mode) begin
        step_count = {WIDTH{1'b1}};
        step_wrap  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      count   <= '0;
      psc_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      match   <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      psc_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      match   <= (load_val == cmp_val);
    end else if (step) begin
      count   <= step_count;
      psc_cnt <= '0;
      tick    <= 1'b1;
      wrap    <= step_wrap;
      match   <= (step_count == cmp_val);
    end else begin
      tick  <= 1'b0;
      wrap  <= 1'b0;
      match <= 1'b0;
      if (en) begin
        psc_cnt <= psc_cnt + PSC_W'(1);
      end
    end
  end

endmodule
